// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for clock lock, holds every domain in reset,
// then releases the domains one at a time in ascending order, each gated by its ack.
module reset_sequencer #(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                locked,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                all_ready,
  output logic                fault,
  output logic [1:0]          fault_stage
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CW = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(ACK_TIMEOUT);
  localparam logic [1:0]    LAST_IDX  = 2'(N_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    WAIT_ACK,
    GAP,
    RUN,
    FAULT
  } state_t;

  state_t          state_reg;
  logic [1:0]      stage_idx_reg;
  logic [CW-1:0]   cnt_reg;
  logic            locked_meta_reg;
  logic            locked_s;
  logic [3:0]      ready_ext;
  logic            lock_lost;

  // Widen the ack vector to the full 2-bit index range so the stage index
  // can select it directly for any N_STAGES.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    if (gi < N_STAGES) begin : g_used
      assign ready_ext[gi] = stage_ready[gi];
    end else begin : g_unused
      assign ready_ext[gi] = 1'b0;
    end
  end

  assign lock_lost = !locked_s &&
                     (state_reg inside {HOLD, WAIT_ACK, GAP, RUN});

  // Stages 0..idx released, everything above still held in reset.
  function automatic logic [N_STAGES-1:0] release_pattern(input logic [1:0] idx);
    logic [N_STAGES-1:0] pat;
    for (int b = 0; b < N_STAGES; b++) begin
      pat[b] = (b > int'(idx));
    end
    return pat;
  endfunction

  always_ff @(posedge pclk) begin
    if (rst) begin
      locked_meta_reg <= 1'b0;
      locked_s        <= 1'b0;
      state_reg       <= IDLE;
      stage_idx_reg   <= 2'd0;
      cnt_reg         <= '0;
      stage_rst       <= '1;
      all_ready       <= 1'b0;
      fault           <= 1'b0;
      fault_stage     <= 2'd0;
    end else begin
      locked_meta_reg <= locked;
      locked_s        <= locked_meta_reg;

      if (lock_lost) begin
        state_reg     <= IDLE;
        stage_idx_reg <= 2'd0;
        cnt_reg       <= '0;
        stage_rst     <= '1;
        all_ready     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (locked_s) begin
              state_reg <= HOLD;
              cnt_reg   <= '0;
            end
          end

          HOLD: begin
            if (cnt_reg == HOLD_LAST) begin
              state_reg <= WAIT_ACK;
              cnt_reg   <= '0;
              stage_rst <= release_pattern(2'd0);
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end

          WAIT_ACK: begin
            // An ack arriving on the timeout cycle still counts as success.
            if (ready_ext[stage_idx_reg]) begin
              cnt_reg <= '0;
              if (stage_idx_reg == LAST_IDX) begin
                state_reg <= RUN;
                stage_rst <= '0;
                all_ready <= 1'b1;
              end else begin
                state_reg <= GAP;
              end
            end else if (cnt_reg == TMO_LAST) begin
              state_reg   <= FAULT;
              stage_rst   <= '1;
              fault       <= 1'b1;
              fault_stage <= stage_idx_reg;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end

          GAP: begin
            if (cnt_reg == GAP_LAST) begin
              state_reg     <= WAIT_ACK;
              stage_idx_reg <= stage_idx_reg + 2'd1;
              cnt_reg       <= '0;
              stage_rst     <= release_pattern(stage_idx_reg + 2'd1);
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end

          RUN: begin
            all_ready <= 1'b1;
          end

          FAULT: begin
            stage_rst <= '1;
          end

          default: begin
            state_reg <= IDLE;
            stage_rst <= '1;
            all_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised and directed bench for reset_sequencer, checked every cycle
// against a behavioural model of the release sequence.
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 10;
  localparam int GAPC = 4;
  localparam int TMO  = 255;

  localparam int MD_IDLE  = 0;
  localparam int MD_HOLD  = 1;
  localparam int MD_WAIT  = 2;
  localparam int MD_GAP   = 3;
  localparam int MD_RUN   = 4;
  localparam int MD_FAULT = 5;

  logic         pclk = 1'b0;
  logic         rst;
  logic         locked;
  logic [N-1:0] stage_ready;
  logic [N-1:0] stage_rst;
  logic         all_ready;
  logic         fault;
  logic [1:0]   fault_stage;

  always #5 pclk = ~pclk;

  reset_sequencer #(
    .N_STAGES   (N),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAPC),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .locked     (locked),
    .stage_ready(stage_ready),
    .stage_rst  (stage_rst),
    .all_ready  (all_ready),
    .fault      (fault),
    .fault_stage(fault_stage)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: a phase, the stage being brought up, and cycles spent in the phase.
  int           m_mode = MD_IDLE;
  int           m_stage = 0;
  int           m_t = 0;
  bit           m_fault = 1'b0;
  int           m_fstage = 0;
  bit           lk_hist[2] = '{1'b0, 1'b0};
  logic [N-1:0] exp_rst = '1;

  int           ack_delay[N];
  int           age[N];
  logic [N-1:0] hold_low = '0;
  bit           glitch_en = 1'b0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step();
    bit ls;
    if (rst) begin
      lk_hist  = '{1'b0, 1'b0};
      m_mode   = MD_IDLE;
      m_stage  = 0;
      m_t      = 0;
      m_fault  = 1'b0;
      m_fstage = 0;
    end else begin
      ls = lk_hist[1];
      lk_hist[1] = lk_hist[0];
      lk_hist[0] = locked;
      if (!ls && m_mode != MD_IDLE && m_mode != MD_FAULT) begin
        m_mode  = MD_IDLE;
        m_stage = 0;
      end else begin
        case (m_mode)
          MD_IDLE: if (ls) begin m_mode = MD_HOLD; m_t = 0; end
          MD_HOLD: begin
            m_t++;
            if (m_t == HOLD) begin m_mode = MD_WAIT; m_t = 0; end
          end
          MD_WAIT: begin
            if (stage_ready[m_stage]) begin
              m_t = 0;
              m_mode = (m_stage == N - 1) ? MD_RUN : MD_GAP;
            end else begin
              m_t++;
              if (m_t > TMO) begin
                m_mode = MD_FAULT; m_fault = 1'b1; m_fstage = m_stage;
              end
            end
          end
          MD_GAP: begin
            m_t++;
            if (m_t == GAPC) begin m_stage++; m_mode = MD_WAIT; m_t = 0; end
          end
          default: ;
        endcase
      end
    end
    // Bits above the current stage stay in reset while sequencing.
    case (m_mode)
      MD_WAIT, MD_GAP: exp_rst = N'(((1 << N) - 1) & ~((2 << m_stage) - 1));
      MD_RUN:          exp_rst = '0;
      default:         exp_rst = '1;
    endcase
  endtask

  task automatic update_ready();
    for (int s = 0; s < N; s++) begin
      if (!exp_rst[s]) age[s] = (age[s] < 0) ? 0 : age[s] + 1;
      else             age[s] = -1;
      stage_ready[s] = (age[s] >= 0) && (age[s] >= ack_delay[s]) && !hold_low[s];
    end
    if (glitch_en && m_mode == MD_RUN && $urandom_range(0, 3) == 0)
      stage_ready = N'($urandom);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    model_step();
    check_val("stage_rst", 32'(stage_rst), 32'(exp_rst));
    check_val("all_ready", 32'(all_ready), 32'(m_mode == MD_RUN));
    check_val("fault", 32'(fault), 32'(m_fault));
    check_val("fault_stage", 32'(fault_stage), 32'(m_fstage));
    update_ready();
  endtask

  function automatic bit cond_met(input int kind, input logic [N-1:0] val);
    case (kind)
      0:       return stage_rst === val;
      1:       return all_ready === 1'b1;
      default: return fault === 1'b1;
    endcase
  endfunction

  // kind 0: stage_rst == val, 1: all_ready, 2: fault. n = cycles waited.
  task automatic wait_until(input string name, input int kind, input logic [N-1:0] val,
                            input int bound, output int n);
    n = 0;
    while (!cond_met(kind, val) && n < bound) begin
      tick();
      n++;
    end
    check_val({name, "_reached"}, 32'(cond_met(kind, val)), 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    locked = 1'b0;
    stage_ready = '0;
    for (int s = 0; s < N; s++) begin ack_delay[s] = 3; age[s] = -1; end

    repeat (3) tick();
    check_val("reset_stage_rst", 32'(stage_rst), 32'h7);
    check_val("reset_all_ready", 32'(all_ready), 32'h0);
    check_val("reset_fault", 32'(fault), 32'h0);
    check_val("reset_fault_stage", 32'(fault_stage), 32'h0);

    // Nominal bring-up: 111 -> 110 -> 100 -> 000, then all_ready.
    locked = 1'b1;
    rst = 1'b0;
    wait_until("nom_110", 0, 3'b110, 100, n);
    check_val("nom_hold_len", 32'(n), 32'd13);
    wait_until("nom_100", 0, 3'b100, 100, n);
    check_val("nom_stage0_len", 32'(n), 32'd8);
    wait_until("nom_000", 0, 3'b000, 100, n);
    check_val("nom_stage1_len", 32'(n), 32'd8);
    wait_until("nom_run", 1, '0, 100, n);
    check_val("nom_run_delay", 32'(n), 32'd4);

    // Lock loss in RUN, then re-lock.
    locked = 1'b0;
    wait_until("runloss_111", 0, 3'b111, 10, n);
    check_val("runloss_latency", 32'(n), 32'd3);
    check_val("runloss_all_ready", 32'(all_ready), 32'h0);
    locked = 1'b1;
    wait_until("relock_run", 1, '0, 300, n);
    check_val("relock_len", 32'(n), 32'd33);

    // Lock loss during the gap after stage 0.
    locked = 1'b0;
    wait_until("gaploss_prep", 0, 3'b111, 10, n);
    locked = 1'b1;
    wait_until("gaploss_110", 0, 3'b110, 100, n);
    repeat (5) tick();
    locked = 1'b0;
    wait_until("gaploss_111", 0, 3'b111, 10, n);
    check_val("gaploss_latency", 32'(n), 32'd3);
    locked = 1'b1;
    wait_until("gaploss_restart", 0, 3'b110, 100, n);
    check_val("gaploss_hold_len", 32'(n), 32'd13);
    wait_until("gaploss_run", 1, '0, 300, n);

    // Stage 1 never acks: fault after the full timeout.
    pulse_rst();
    hold_low = 3'b010;
    wait_until("tmo_100", 0, 3'b100, 200, n);
    wait_until("tmo_fault", 2, '0, 400, n);
    check_val("tmo_latency", 32'(n), 32'd256);
    check_val("tmo_fault_stage", 32'(fault_stage), 32'd1);
    check_val("tmo_stage_rst", 32'(stage_rst), 32'h7);
    repeat (20) tick();
    hold_low = '0;
    locked = 1'b0;
    repeat (10) tick();
    locked = 1'b1;
    repeat (10) tick();
    check_val("tmo_sticky", 32'(fault), 32'h1);

    // Ack lands exactly on the last allowed cycle.
    ack_delay[0] = 255;
    pulse_rst();
    wait_until("edge_110", 0, 3'b110, 100, n);
    wait_until("edge_100", 0, 3'b100, 400, n);
    check_val("edge_len", 32'(n), 32'd260);
    check_val("edge_no_fault", 32'(fault), 32'h0);
    ack_delay[0] = 3;
    wait_until("edge_run", 1, '0, 300, n);

    // Reset pulse while waiting on stage 2.
    ack_delay[2] = 50;
    pulse_rst();
    wait_until("mid_000", 0, 3'b000, 200, n);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_val("mid_stage_rst", 32'(stage_rst), 32'h7);
    check_val("mid_fault", 32'(fault), 32'h0);
    check_val("mid_all_ready", 32'(all_ready), 32'h0);
    rst = 1'b0;
    ack_delay[2] = 3;
    wait_until("mid_restart", 0, 3'b110, 100, n);
    check_val("mid_hold_len", 32'(n), 32'd13);
    wait_until("mid_run", 1, '0, 300, n);

    // Random lock flaps, reset pulses, ack delays and RUN-time ready glitches.
    glitch_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        for (int s = 0; s < N; s++)
          ack_delay[s] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(250, 258))
                                                     : int'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 199) == 0) locked = ~locked;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_STAGES, default 3: number of sequenced reset domains (1..4).
REQ-002 Parameter HOLD_CYCLES, default 10: cycles all resets stay asserted after lock is seen.
REQ-003 Parameter GAP_CYCLES, default 4: cycles between one stage's ack and the next stage's release.
REQ-004 Parameter ACK_TIMEOUT, default 255: maximum cycles a stage may take to raise its ready.
REQ-005 pclk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 locked  input  1  clock-manager lock, asynchronous to pclk.
REQ-008 stage_ready  input  N_STAGES  per-stage "initialised" ack, level, synchronous to pclk.
REQ-009 stage_rst  output  N_STAGES  per-stage reset, active high, registered.
REQ-010 all_ready  output  1  high when every stage is released and acked, registered.
REQ-011 fault  output  1  sticky ack-timeout flag, registered.
REQ-012 fault_stage  output  2  index of the stage that timed out, registered.

Function
REQ-013 locked SHALL pass through a 2-flop synchronizer; only locked_s (2-cycle delayed) is used internally.
REQ-014 States SHALL be: IDLE, HOLD, WAIT_ACK, GAP, RUN, FAULT; stage index i (2 bits) selects the current stage.
REQ-015 IDLE: stage_rst all ones, all_ready 0, i=0; locked_s=1 -> HOLD with counter cleared.
REQ-016 HOLD: stage_rst all ones; counter increments each cycle; at count HOLD_CYCLES-1 -> WAIT_ACK, stage_rst[0] low from the next cycle.
REQ-017 WAIT_ACK: stage_rst[i] and all lower bits low, higher bits high; timeout counter increments each cycle.
REQ-018 WAIT_ACK with stage_ready[i]=1: if i=N_STAGES-1 -> RUN, else -> GAP with counter cleared.
REQ-019 WAIT_ACK with stage_ready[i]=0 and timeout count = ACK_TIMEOUT -> FAULT; ready and timeout in the same cycle resolve as ready.
REQ-020 GAP: reset pattern unchanged; at count GAP_CYCLES-1, i<=i+1, -> WAIT_ACK; stage_rst[i+1] low from the next cycle.
REQ-021 RUN: stage_rst all zeros, all_ready 1; stage_ready deassertion in RUN is ignored.
REQ-022 FAULT: stage_rst all ones, all_ready 0, fault 1, fault_stage=i; FAULT exits only on rst.
REQ-023 locked_s=0 in HOLD, WAIT_ACK, GAP or RUN -> IDLE; stage_rst all ones and all_ready 0 from the following cycle.
REQ-024 Release order SHALL be strictly ascending index; no two stages are released in the same cycle.
REQ-025 Counters SHALL be wide enough for max(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT) and never wrap while counting.
REQ-026 Unused stage_rst bits above N_STAGES-1 do not exist; fault_stage upper bits are zero when N_STAGES<=2.

Reset
REQ-027 rst=1 SHALL force IDLE, i=0, counters 0, stage_rst all ones, all_ready 0, fault 0, fault_stage 0 on the next edge.
REQ-028 rst SHALL take priority over every other input, including mid-sequence and in FAULT.
REQ-029 Synchronizer flops SHALL reset to 0, so locked_s=0 for 2 cycles after rst deasserts.

Verification
REQ-030 Nominal: defaults; locked=1 and each stage_ready raised 3 cycles after its stage_rst falls -> stage_rst 111->110->100->000 with HOLD 10 and 4-cycle gaps; all_ready=1 after the third ack.
REQ-031 Timeout: stage_ready[1] held 0 -> 256 cycles after stage_rst[1] falls, fault=1, fault_stage=1, stage_rst=111, held until rst.
REQ-032 Lock loss: locked drops in GAP after stage 0 -> stage_rst=111 within 3 cycles of the drop; locked restored -> full sequence restarts from HOLD.
REQ-033 Lock loss in RUN: all_ready 1->0 and stage_rst 000->111 within 3 cycles; re-lock re-sequences to RUN.
REQ-034 Boundary: stage_ready[0] rises exactly at timeout count 255 -> GAP entered, fault stays 0.
REQ-035 Reset mid-sequence: rst pulsed 1 cycle during WAIT_ACK stage 2 -> next edge stage_rst=111, fault=0, all_ready=0; sequence restarts once locked_s returns.
